// File: rtl/priority_encoder_8to3.sv
// Registered 8-to-3 priority encoder with sticky request capture and a
// valid/ready output handshake; one encoded index is retired per accepted transfer.
module priority_encoder_8to3 #(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] mask,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [2:0] out_code,
  output logic [7:0] pending,
  output logic       overflow,
  input  logic       clr_ovf
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic       ack;
  logic [7:0] ack_onehot;
  logic [7:0] elig;
  logic [2:0] sel_code;
  logic       load_code;
  logic       ovf_set;

  // Later loop iterations overwrite earlier ones, so the scan direction sets the winner.
  function automatic logic [2:0] select_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    if (HIGH_FIRST) begin
      for (int i = 0; i < 8; i++)
        if (v[i]) idx = 3'(i);
    end else begin
      for (int i = 7; i >= 0; i--)
        if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // The index being retired this cycle is excluded from both eligibility and overflow.
  always_comb begin
    ack        = out_valid & out_ready;
    ack_onehot = ack ? (8'b1 << out_code) : 8'b0;
    elig       = pending & ~ack_onehot & mask;
    sel_code   = select_idx(elig);
    ovf_set    = |(req & pending & ~ack_onehot);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (elig != 8'b0) state_d = PRESENT;
      PRESENT: if (out_ready && (elig == 8'b0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A held code only changes once the consumer has taken it.
  always_comb begin
    out_valid = (state_q == PRESENT);
    load_code = ((state_q == IDLE) || out_ready) && (elig != 8'b0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pending  <= 8'b0;
      out_code <= 3'b000;
      overflow <= 1'b0;
    end else begin
      state_q  <= state_d;
      pending  <= (pending & ~ack_onehot) | req;
      if (load_code) out_code <= sel_code;
      overflow <= ovf_set | (overflow & ~clr_ovf);
    end
  end

endmodule

// File: tb/tb_priority_encoder_8to3.sv
// Scoreboard bench for priority_encoder_8to3: the stimulus process queues expected
// codes, a monitor pops and compares them on every accepted transfer.
module tb_priority_encoder_8to3;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] req_lo;
  logic [7:0] mask;
  logic       out_ready;
  logic       clr_ovf;

  logic       hi_valid, lo_valid;
  logic [2:0] hi_code, lo_code;
  logic [7:0] hi_pending, lo_pending;
  logic       hi_ovf, lo_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  logic [2:0] q_hi[$];
  logic [2:0] q_lo[$];
  logic [2:0] exp_hi, exp_lo;

  priority_encoder_8to3 #(.HIGH_FIRST(1'b1)) dut_hi (
    .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .out_ready(out_ready),
    .out_valid(hi_valid), .out_code(hi_code), .pending(hi_pending),
    .overflow(hi_ovf), .clr_ovf(clr_ovf)
  );

  priority_encoder_8to3 #(.HIGH_FIRST(1'b0)) dut_lo (
    .clk(clk), .rst_n(rst_n), .req(req_lo), .mask(mask), .out_ready(out_ready),
    .out_valid(lo_valid), .out_code(lo_code), .pending(lo_pending),
    .overflow(lo_ovf), .clr_ovf(clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted transfer must match the head of its queue.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_ready && hi_valid) begin
        n_tests++;
        if (q_hi.size() == 0) begin
          n_fail++;
          $display("FAIL hi_unexpected: code %0d transferred, none expected", hi_code);
        end else begin
          exp_hi = q_hi.pop_front();
          if (hi_code !== exp_hi) begin
            n_fail++;
            $display("FAIL hi_code: got %0d, expected %0d", hi_code, exp_hi);
          end
        end
      end
      if (rst_n && out_ready && lo_valid) begin
        n_tests++;
        if (q_lo.size() == 0) begin
          n_fail++;
          $display("FAIL lo_unexpected: code %0d transferred, none expected", lo_code);
        end else begin
          exp_lo = q_lo.pop_front();
          if (lo_code !== exp_lo) begin
            n_fail++;
            $display("FAIL lo_code: got %0d, expected %0d", lo_code, exp_lo);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; req = 8'hFF; req_lo = 8'hFF; mask = 8'hFF;
    out_ready = 1'b0; clr_ovf = 1'b0;

    // Reset with all requests asserted
    repeat (2) step();
    check("rst_pending", hi_pending, 8'h00);
    check("rst_valid", hi_valid, 1'b0);
    check("rst_code", hi_code, 3'd0);
    check("rst_ovf", hi_ovf, 1'b0);
    check("rst_lo_pending", lo_pending, 8'h00);
    rst_n = 1'b1; req = 8'h00; req_lo = 8'h00; out_ready = 1'b1;
    step();

    // Single request, two-cycle latency, one transfer
    req = 8'b0010_0000; q_hi.push_back(3'd5);
    step();
    check("single_pending", hi_pending, 8'h20);
    check("single_valid_early", hi_valid, 1'b0);
    req = 8'h00;
    step();
    check("single_valid", hi_valid, 1'b1);
    check("single_code", hi_code, 3'd5);
    step();
    check("single_idle", hi_valid, 1'b0);
    check("single_cleared", hi_pending, 8'h00);

    // Priority drain on both instances
    req = 8'hFF; req_lo = 8'hFF;
    for (int i = 7; i >= 0; i--) q_hi.push_back(3'(i));
    for (int i = 0; i < 8; i++) q_lo.push_back(3'(i));
    step();
    req = 8'h00; req_lo = 8'h00;
    repeat (9) step();
    check("drain_hi_idle", hi_valid, 1'b0);
    check("drain_lo_idle", lo_valid, 1'b0);
    check("drain_hi_left", q_hi.size(), 0);
    check("drain_lo_left", q_lo.size(), 0);
    check("drain_hi_pending", hi_pending, 8'h00);

    // Backpressure: held code survives a higher-priority arrival
    out_ready = 1'b0; req = 8'b0000_1000; q_hi.push_back(3'd3);
    step();
    req = 8'h00;
    step();
    check("bp_code_first", hi_code, 3'd3);
    req = 8'b0100_0000;
    step();
    req = 8'h00;
    step();
    check("bp_valid_held", hi_valid, 1'b1);
    check("bp_code_held", hi_code, 3'd3);
    check("bp_pending", hi_pending, 8'h48);
    q_hi.push_back(3'd6); out_ready = 1'b1;
    step();
    check("bp_next_code", hi_code, 3'd6);
    step();
    check("bp_idle", hi_valid, 1'b0);

    // Mask: masked bit retained, served one cycle after the mask opens
    mask = 8'h01; req = 8'h81; q_hi.push_back(3'd0);
    step();
    req = 8'h00;
    step();
    check("mask_code0", hi_code, 3'd0);
    step();
    check("mask_retained", hi_pending, 8'h80);
    check("mask_idle", hi_valid, 1'b0);
    step();
    check("mask_still_idle", hi_valid, 1'b0);
    mask = 8'hFF; q_hi.push_back(3'd7);
    step();
    check("mask_open_valid", hi_valid, 1'b1);
    check("mask_open_code", hi_code, 3'd7);
    step();
    check("mask_drained", hi_pending, 8'h00);

    // Overflow set/clear, set beating clear, and coincident ack
    out_ready = 1'b0; req = 8'h04; q_hi.push_back(3'd2);
    step();
    check("ovf_first_req", hi_ovf, 1'b0);
    step();
    check("ovf_set", hi_ovf, 1'b1);
    req = 8'h00; clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("ovf_clear", hi_ovf, 1'b0);
    req = 8'h04; clr_ovf = 1'b1;
    step();
    req = 8'h00; clr_ovf = 1'b0;
    check("ovf_set_wins", hi_ovf, 1'b1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("ovf_clear2", hi_ovf, 1'b0);
    out_ready = 1'b1; req = 8'h04; q_hi.push_back(3'd2);
    step();
    req = 8'h00;
    check("coinc_no_ovf", hi_ovf, 1'b0);
    check("coinc_pending", hi_pending, 8'h04);
    check("coinc_gap", hi_valid, 1'b0);
    step();
    check("coinc_valid", hi_valid, 1'b1);
    check("coinc_code", hi_code, 3'd2);
    step();
    check("coinc_drained", hi_pending, 8'h00);

    // Reset in the middle of a presented transfer discards it
    out_ready = 1'b0; req = 8'h10;
    step();
    req = 8'h00;
    step();
    check("abort_presented", hi_valid, 1'b1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("abort_valid", hi_valid, 1'b0);
    check("abort_pending", hi_pending, 8'h00);
    check("abort_code", hi_code, 3'd0);
    out_ready = 1'b1;
    repeat (3) step();
    check("abort_quiet", hi_valid, 1'b0);

    check("final_hi_queue", q_hi.size(), 0);
    check("final_lo_queue", q_lo.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
